// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Sequences the program counter and the single-outstanding instruction-fetch handshake.
//   Two-state FSM: FETCH issues a request at PC_Out and waits for IMem_Ack (bounded by
//   MAX_WAIT cycles), EXEC presents the fetched PC to the datapath until the next PC is
//   chosen (trap, stall, branch, misaligned branch or sequential PC+4).
//
// Ports
//   CLK          in   1   system clock, rising edge
//   RST          in   1   synchronous, active-high reset
//   Stall        in   1   hold the current instruction in EXEC
//   Br_Taken     in   1   redirect request, sampled in EXEC
//   Br_Target    in   32  redirect target address
//   Trap         in   1   exception request, sampled in EXEC, overrides Stall
//   IMem_Ack     in   1   instruction memory accepted/returned the request
//   IMem_Req     out  1   fetch request, high throughout FETCH (low while RST is high)
//   IMem_Addr    out  32  fetch address, equal to PC_Out
//   PC_Out       out  32  current PC register
//   Instr_Valid  out  1   high in EXEC
//   Misaligned   out  1   one-cycle pulse: branch target had [1:0] != 0
//   Timeout      out  1   one-cycle pulse: fetch not acknowledged within MAX_WAIT cycles

module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter int unsigned MAX_WAIT  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall,
    input  logic        Br_Taken,
    input  logic [31:0] Br_Target,
    input  logic        Trap,
    input  logic        IMem_Ack,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    output logic [31:0] PC_Out,
    output logic        Instr_Valid,
    output logic        Misaligned,
    output logic        Timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    // The counter holds the number of unacknowledged cycles already spent on this fetch;
    // the cycle in which it would reach MAX_WAIT is the timeout cycle, so it is cleared there.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [0:0] {
        StFetch,
        StExec
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] wait_cnt;

    // Request is combinational so it drops in the reset cycle itself.
    assign IMem_Req  = (state == StFetch) && !RST;
    assign IMem_Addr = PC_Out;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= StFetch;
            PC_Out      <= RESET_VEC;
            wait_cnt    <= '0;
            Instr_Valid <= 1'b0;
            Misaligned  <= 1'b0;
            Timeout     <= 1'b0;
        end else begin
            // Pulses last exactly one cycle.
            Misaligned <= 1'b0;
            Timeout    <= 1'b0;

            case (state)
                StFetch: begin
                    if (IMem_Ack) begin
                        state       <= StExec;
                        Instr_Valid <= 1'b1;
                        wait_cnt    <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Give up and re-issue from the trap vector.
                        PC_Out   <= TRAP_VEC;
                        Timeout  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                StExec: begin
                    if (Trap) begin
                        PC_Out      <= TRAP_VEC;
                        state       <= StFetch;
                        Instr_Valid <= 1'b0;
                    end else if (Stall) begin
                        Instr_Valid <= 1'b1;
                    end else if (Br_Taken) begin
                        if (Br_Target[1:0] == 2'b00) begin
                            PC_Out <= Br_Target;
                        end else begin
                            PC_Out     <= TRAP_VEC;
                            Misaligned <= 1'b1;
                        end
                        state       <= StFetch;
                        Instr_Valid <= 1'b0;
                    end else begin
                        // 32-bit modulo increment, wraps at the top of the address space.
                        PC_Out      <= PC_Out + 32'd4;
                        state       <= StFetch;
                        Instr_Valid <= 1'b0;
                    end
                    wait_cnt <= '0;
                end

                default: begin
                    state       <= StFetch;
                    PC_Out      <= RESET_VEC;
                    wait_cnt    <= '0;
                    Instr_Valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
